// File: rtl/wb_port_arbiter_pkg.sv
// Writeback request types and helpers shared by the writeback arbiter, ROB and RF write ports.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package wb_port_arbiter_pkg;

  localparam int SQN_W        = 6;
  localparam int TAG_W        = 6;
  localparam int NM_W         = 5;
  localparam int DATA_W       = 32;
  localparam int STARVE_CNT_W = 4;

  typedef struct packed {
    logic              valid;
    logic [SQN_W-1:0]  sqN;
    logic [TAG_W-1:0]  tagDst;
    logic [NM_W-1:0]   nmDst;
    logic [DATA_W-1:0] result;
  } WBReq_t;

  // An entry is flushed when it is strictly younger than the branch sqN (wrap-aware compare).
  function automatic logic isKilled(input logic [SQN_W-1:0] sqN,
                                    input logic [SQN_W-1:0] invSqN,
                                    input logic             inv);
    logic [SQN_W-1:0] diff;
    diff = sqN - invSqN;
    return inv && !diff[SQN_W-1] && (diff != '0);
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin find-first-set over slot requests 1..NUM_REQ-1, starting at rrPtr and wrapping to 1.
// Latency: purely combinational.
// Backpressure: none; found=0 when no slot requests.
module wb_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:1] req,
  input  logic [IDX_W-1:0]   rrPtr,
  output logic [IDX_W-1:0]   grantIdx,
  output logic               found
);

  // Walk NUM_REQ-1 positions from rrPtr; first requesting slot wins.
  always_comb begin
    int cand;
    grantIdx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      cand = int'(rrPtr) + k;
      if (cand > NUM_REQ - 1) cand = cand - (NUM_REQ - 1);
      if (!found && req[cand]) begin
        found    = 1'b1;
        grantIdx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one writeback lane between a single-cycle ALU (req 0) and parked multi-cycle units; optional WB_ARB_SKID_RELEASE_EN.
// Latency: 1 edge for req 0, 2 edges for slow units (capture into slot, then win).
// Backpressure: OUT_stall[i] while slot i is full (released in the grant cycle with WB_ARB_SKID_RELEASE_EN); OUT_stall[0]=0.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              IN_valid,
  input  logic [NUM_REQ-1:0][SQN_W-1:0]   IN_sqN,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   IN_tagDst,
  input  logic [NUM_REQ-1:0][NM_W-1:0]    IN_nmDst,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  IN_result,
  output logic [NUM_REQ-1:0]              OUT_stall,
  input  logic                            IN_invalidate,
  input  logic [SQN_W-1:0]                IN_invalidateSqN,
  output logic                            OUT_blockFast,
  output logic                            OUT_valid,
  output logic [SQN_W-1:0]                OUT_sqN,
  output logic [TAG_W-1:0]                OUT_tagDst,
  output logic [NM_W-1:0]                 OUT_nmDst,
  output logic [DATA_W-1:0]               OUT_result
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [STARVE_CNT_W-1:0] STARVE_TH  = STARVE_CNT_W'(STARVE_LIMIT - 1);
  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = '1;

  WBReq_t                  inReq [NUM_REQ-1:0];
  WBReq_t                  slot  [NUM_REQ-1:1];
  WBReq_t                  win;
  logic [STARVE_CNT_W-1:0] starveCnt [NUM_REQ-1:1];
  logic [NUM_REQ-1:1]      slotValid, slotKill, slotLive, inKill, grant, capture;
  logic [IDX_W-1:0]        rrPtr, pickIdx;
  logic                    pickFound, aluLive, slowGrant, anyStarve;

  // Bundle the flat input ports into request records.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      inReq[i].valid  = IN_valid[i];
      inReq[i].sqN    = IN_sqN[i];
      inReq[i].tagDst = IN_tagDst[i];
      inReq[i].nmDst  = IN_nmDst[i];
      inReq[i].result = IN_result[i];
    end
  end

  // Apply the branch flush before arbitration so a killed entry can never be picked.
  always_comb begin
    aluLive = IN_valid[0] && !isKilled(IN_sqN[0], IN_invalidateSqN, IN_invalidate);
    for (int i = 1; i < NUM_REQ; i++) begin
      slotValid[i] = slot[i].valid;
      slotKill[i]  = slot[i].valid && isKilled(slot[i].sqN, IN_invalidateSqN, IN_invalidate);
      slotLive[i]  = slot[i].valid && !slotKill[i];
      inKill[i]    = isKilled(IN_sqN[i], IN_invalidateSqN, IN_invalidate);
    end
  end

  wb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) picker (
    .req      (slotLive),
    .rrPtr    (rrPtr),
    .grantIdx (pickIdx),
    .found    (pickFound)
  );

  // Live ALU result always beats parked slots; otherwise the picked slot is granted.
  always_comb begin
    slowGrant = !aluLive && pickFound;
    win       = '0;
    if (aluLive) win = inReq[0];
    for (int i = 1; i < NUM_REQ; i++) begin
      grant[i] = slowGrant && (pickIdx == IDX_W'(i));
      if (grant[i]) win = slot[i];
    end
  end

  // Stall and capture qualification per slow requester.
  always_comb begin
    OUT_stall[0] = 1'b0;
    for (int i = 1; i < NUM_REQ; i++) begin
`ifdef WB_ARB_SKID_RELEASE_EN
      OUT_stall[i] = slotValid[i] && !grant[i];
`else
      OUT_stall[i] = slotValid[i];
`endif
      capture[i] = IN_valid[i] && !OUT_stall[i] && !inKill[i];
    end
  end

  // Any live slot waiting long enough asks the scheduler to hold off ALU issue.
  always_comb begin
    anyStarve = 1'b0;
    for (int i = 1; i < NUM_REQ; i++) begin
      if (slotLive[i] && (starveCnt[i] >= STARVE_TH)) anyStarve = 1'b1;
    end
  end

  // Holding slots and their starvation counters; a capture overrides a same-edge free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REQ; i++) begin
        slot[i]      <= '0;
        starveCnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REQ; i++) begin
        if (capture[i]) begin
          slot[i] <= inReq[i];
        end else if (grant[i] || slotKill[i]) begin
          slot[i].valid <= 1'b0;
        end
        if (slotLive[i] && !grant[i]) begin
          starveCnt[i] <= (starveCnt[i] == STARVE_MAX) ? STARVE_MAX : starveCnt[i] + 1'b1;
        end else begin
          starveCnt[i] <= '0;
        end
      end
    end
  end

  // Round-robin pointer advance and fast-issue block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr         <= IDX_W'(1);
      OUT_blockFast <= 1'b0;
    end else if (slowGrant) begin
      rrPtr         <= (pickIdx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : pickIdx + 1'b1;
      OUT_blockFast <= 1'b0;
    end else if (anyStarve) begin
      OUT_blockFast <= 1'b1;
    end
  end

  // Register the winner onto the lane; fields hold when nothing wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OUT_valid  <= 1'b0;
      OUT_sqN    <= '0;
      OUT_tagDst <= '0;
      OUT_nmDst  <= '0;
      OUT_result <= '0;
    end else begin
      OUT_valid <= win.valid;
      if (win.valid) begin
        OUT_sqN    <= win.sqN;
        OUT_tagDst <= win.tagDst;
        OUT_nmDst  <= win.nmDst;
        OUT_result <= win.result;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table for the ALU/kill path plus hand sequences.
// Latency expectations: ALU 1 edge, slow units 2 edges.
// Backpressure: slow drivers hold while OUT_stall is high.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int N = 3;
  localparam int L = 4;

  logic                       clk, rst;
  logic [N-1:0]               IN_valid;
  logic [N-1:0][SQN_W-1:0]    IN_sqN;
  logic [N-1:0][TAG_W-1:0]    IN_tagDst;
  logic [N-1:0][NM_W-1:0]     IN_nmDst;
  logic [N-1:0][DATA_W-1:0]   IN_result;
  logic [N-1:0]               OUT_stall;
  logic                       IN_invalidate;
  logic [SQN_W-1:0]           IN_invalidateSqN;
  logic                       OUT_blockFast, OUT_valid;
  logic [SQN_W-1:0]           OUT_sqN;
  logic [TAG_W-1:0]           OUT_tagDst;
  logic [NM_W-1:0]            OUT_nmDst;
  logic [DATA_W-1:0]          OUT_result;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter #(.NUM_REQ(N), .STARVE_LIMIT(L)) dut (
    .clk(clk), .rst(rst),
    .IN_valid(IN_valid), .IN_sqN(IN_sqN), .IN_tagDst(IN_tagDst),
    .IN_nmDst(IN_nmDst), .IN_result(IN_result), .OUT_stall(OUT_stall),
    .IN_invalidate(IN_invalidate), .IN_invalidateSqN(IN_invalidateSqN),
    .OUT_blockFast(OUT_blockFast), .OUT_valid(OUT_valid), .OUT_sqN(OUT_sqN),
    .OUT_tagDst(OUT_tagDst), .OUT_nmDst(OUT_nmDst), .OUT_result(OUT_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TAG_W-1:0] tagOf(input logic [SQN_W-1:0] s);
    return s ^ 6'h15;
  endfunction
  function automatic logic [NM_W-1:0] nmOf(input logic [SQN_W-1:0] s);
    return s[4:0] ^ 5'h0A;
  endfunction
  function automatic logic [DATA_W-1:0] resOf(input logic [SQN_W-1:0] s);
    return {26'h0, s} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clearIn();
    IN_valid = '0; IN_sqN = '0; IN_tagDst = '0; IN_nmDst = '0; IN_result = '0;
    IN_invalidate = 1'b0; IN_invalidateSqN = '0;
  endtask

  task automatic setReq(input int i, input logic [SQN_W-1:0] s);
    IN_valid[i]  = 1'b1;
    IN_sqN[i]    = s;
    IN_tagDst[i] = tagOf(s);
    IN_nmDst[i]  = nmOf(s);
    IN_result[i] = resOf(s);
  endtask

  task automatic dropReq(input int i);
    IN_valid[i] = 1'b0;
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clearIn();
    rst = 1'b1;
    nextCyc();
    rst = 1'b0;
  endtask

  task automatic chkOut(input string name, input logic v, input logic [SQN_W-1:0] s);
    chk({name, "_valid"}, OUT_valid, v);
    if (v) begin
      chk({name, "_sqN"}, OUT_sqN, s);
      chk({name, "_result"}, OUT_result, resOf(s));
    end
  endtask

  // Requester 0 must never be stalled.
  always @(negedge clk) if (!rst) chk("stall0_zero", OUT_stall[0], 1'b0);

  typedef struct {
    logic             v;
    logic [SQN_W-1:0] sqN;
    logic             inv;
    logic [SQN_W-1:0] invSqN;
    logic             expV;
    logic [SQN_W-1:0] expSqN;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int sent, got, lastCyc, expLast;
    logic accepted;

    //           v     sqN     inv   invSqN  expV  expSqN (held fields on expV=0)
    vecs[0] = '{1'b1, 6'd3,  1'b0, 6'd0,  1'b1, 6'd3};
    vecs[1] = '{1'b1, 6'd10, 1'b1, 6'd8,  1'b0, 6'd3};
    vecs[2] = '{1'b1, 6'd8,  1'b1, 6'd8,  1'b1, 6'd8};
    vecs[3] = '{1'b1, 6'd7,  1'b1, 6'd8,  1'b1, 6'd7};
    vecs[4] = '{1'b1, 6'd2,  1'b1, 6'd60, 1'b0, 6'd7};
    vecs[5] = '{1'b0, 6'd9,  1'b0, 6'd0,  1'b0, 6'd7};
    vecs[6] = '{1'b1, 6'd60, 1'b1, 6'd2,  1'b1, 6'd60};
    vecs[7] = '{1'b1, 6'd63, 1'b0, 6'd0,  1'b1, 6'd63};
    vecs[8] = '{1'b1, 6'd33, 1'b1, 6'd0,  1'b1, 6'd33};
    vecs[9] = '{1'b1, 6'd31, 1'b1, 6'd0,  1'b0, 6'd33};

    // Reset state
    clearIn();
    rst = 1'b1;
    #2;
    chk("rst_valid", OUT_valid, 1'b0);
    chk("rst_sqN", OUT_sqN, '0);
    chk("rst_result", OUT_result, '0);
    chk("rst_stall", OUT_stall, '0);
    chk("rst_blockFast", OUT_blockFast, 1'b0);
    nextCyc();
    rst = 1'b0;

    // Table: ALU path, kill rule, hold-on-idle
    for (int r = 0; r < 10; r++) begin
      clearIn();
      if (vecs[r].v) setReq(0, vecs[r].sqN);
      else begin IN_valid[0] = 1'b0; IN_sqN[0] = vecs[r].sqN; end
      IN_invalidate    = vecs[r].inv;
      IN_invalidateSqN = vecs[r].invSqN;
      nextCyc();
      clearIn();
      #2;
      chk($sformatf("vec%0d_valid", r), OUT_valid, vecs[r].expV);
      chk($sformatf("vec%0d_sqN", r), OUT_sqN, vecs[r].expSqN);
      chk($sformatf("vec%0d_tag", r), OUT_tagDst, tagOf(vecs[r].expSqN));
      chk($sformatf("vec%0d_result", r), OUT_result, resOf(vecs[r].expSqN));
    end

    // Reset mid-traffic with both slots full
    doReset();
    setReq(0, 6'd1); setReq(1, 6'd11); setReq(2, 6'd12);
    nextCyc();
    clearIn(); setReq(0, 6'd2);
    #2;
    chk("mid_stall_before", OUT_stall, 3'b110);
    chkOut("mid_out_before", 1'b1, 6'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", OUT_stall, '0);
    chk("mid_rst_valid", OUT_valid, 1'b0);
    chk("mid_rst_blockFast", OUT_blockFast, 1'b0);
    nextCyc();
    clearIn();
    rst = 1'b0;

    // Round-robin with rr=1 after reset: slot1, ALU x2, then slot2 before slot1
    doReset();
    setReq(1, 6'd11); setReq(2, 6'd12);                 // c0
    #2; chk("rr_c0_stall", OUT_stall, 3'b000);
    nextCyc(); clearIn();                               // c1
    #2; chk("rr_c1_stall", OUT_stall, 3'b110); chkOut("rr_c1", 1'b0, 6'd0);
    nextCyc(); setReq(0, 6'd40); setReq(1, 6'd13);      // c2
    #2; chkOut("rr_c2", 1'b1, 6'd11);
    nextCyc(); clearIn(); setReq(0, 6'd41);             // c3
    #2; chk("rr_c3_stall", OUT_stall, 3'b110); chkOut("rr_c3", 1'b1, 6'd40);
    nextCyc(); clearIn();                               // c4
    #2; chkOut("rr_c4", 1'b1, 6'd41);
    nextCyc();                                          // c5
    #2; chkOut("rr_c5", 1'b1, 6'd12);
    nextCyc();                                          // c6
    #2; chkOut("rr_c6", 1'b1, 6'd13);
    nextCyc();                                          // c7
    #2; chkOut("rr_c7", 1'b0, 6'd0); chk("rr_c7_stall", OUT_stall, 3'b000);

    // Invalidate held slots, equal sqN survives, wrapped incoming killed
    doReset();
    setReq(0, 6'd1); setReq(1, 6'd10); setReq(2, 6'd7); // c0
    nextCyc(); clearIn(); setReq(0, 6'd2);              // c1
    #2; chk("inv_c1_stall", OUT_stall, 3'b110);
    nextCyc(); clearIn();                               // c2
    IN_invalidate = 1'b1; IN_invalidateSqN = 6'd8;
    #2; chkOut("inv_c2", 1'b1, 6'd2);
    nextCyc(); clearIn();                               // c3
    #2; chkOut("inv_c3", 1'b1, 6'd7); chk("inv_c3_stall", OUT_stall, 3'b000);
    nextCyc(); setReq(0, 6'd3); setReq(1, 6'd8);        // c4
    #2; chkOut("inv_c4", 1'b0, 6'd0);
    nextCyc(); clearIn();                               // c5
    IN_invalidate = 1'b1; IN_invalidateSqN = 6'd8;
    #2; chk("inv_c5_stall1", OUT_stall[1], 1'b1); chkOut("inv_c5", 1'b1, 6'd3);
    nextCyc(); clearIn(); setReq(2, 6'd2);              // c6
    IN_invalidate = 1'b1; IN_invalidateSqN = 6'd60;
    #2; chkOut("inv_c6_eq", 1'b1, 6'd8);
    nextCyc(); clearIn();                               // c7
    #2; chk("inv_c7_stall", OUT_stall, 3'b000); chkOut("inv_c7", 1'b0, 6'd0);

    // ALU priority and starvation block
    doReset();
    setReq(0, 6'd32); setReq(1, 6'd5);                  // c0
    for (int c = 1; c <= 6; c++) begin
      nextCyc(); clearIn(); setReq(0, 6'(32 + c));
      #2;
      chk($sformatf("prio_c%0d_stall1", c), OUT_stall[1], 1'b1);
      chk($sformatf("prio_c%0d_block", c), OUT_blockFast, (c >= 1 + L));
      chkOut($sformatf("prio_c%0d", c), 1'b1, 6'(32 + c - 1));
    end
    nextCyc(); clearIn();                               // c7: ALU dropped
    #2; chk("prio_c7_block", OUT_blockFast, 1'b1); chkOut("prio_c7", 1'b1, 6'd38);
    nextCyc();                                          // c8
    #2;
    chkOut("prio_c8_div", 1'b1, 6'd5);
    chk("prio_c8_tag", OUT_tagDst, tagOf(6'd5));
    chk("prio_c8_nm", OUT_nmDst, nmOf(6'd5));
    chk("prio_c8_block", OUT_blockFast, 1'b0);
    chk("prio_c8_stall1", OUT_stall[1], 1'b0);

    // Throughput: 8 back-to-back MUL results on requester 1, ALU idle
    doReset();
    sent = 0; got = 0; lastCyc = -1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (sent < 8) setReq(1, 6'(16 + sent)); else dropReq(1);
      #2;
      if (OUT_valid) begin
        chk($sformatf("tp_order%0d", got), OUT_sqN, 6'(16 + got));
        got++;
        lastCyc = c;
      end
      accepted = IN_valid[1] && !OUT_stall[1];
      nextCyc();
      if (accepted) sent++;
    end
`ifdef WB_ARB_SKID_RELEASE_EN
    expLast = 9;
`else
    expLast = 16;
`endif
    chk("tp_count", 64'(got), 64'd8);
    chk("tp_last_cycle", 64'(lastCyc), 64'(expLast));
    clearIn();
    nextCyc();
    #2; chk("tp_idle_valid", OUT_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
